// File: rtl/vector_issue_ctrl.sv
// Issue controller for the vector lane array: broadcasts one instruction to all lanes,
// waits for every lane's done and returns a completion response carrying any read-out vector.
module vector_issue_ctrl #(
    parameter int unsigned lanes_p    = 4,
    parameter int unsigned vlen_p     = 8,
    parameter int unsigned vdw_p      = 32,
    parameter int unsigned els_p      = 32,
    parameter int unsigned op_width_p = 4,
    localparam int unsigned v_addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        instr_v_i,
    output logic                        instr_ready_o,
    input  logic [op_width_p-1:0]       instr_op_i,
    input  logic [v_addr_width_lp-1:0]  instr_rd_i,
    input  logic [v_addr_width_lp-1:0]  instr_rs0_i,
    input  logic [v_addr_width_lp-1:0]  instr_rs1_i,
    input  logic [vdw_p-1:0]            instr_scalar_i,
    input  logic [vdw_p-1:0]            instr_w_data_i,
    output logic [op_width_p-1:0]       op_o,
    output logic                        start_o,
    output logic [vdw_p-1:0]            scalar_o,
    output logic [vdw_p-1:0]            w_data_o,
    output logic [v_addr_width_lp-1:0]  rd_o,
    output logic [v_addr_width_lp-1:0]  rs0_o,
    output logic [v_addr_width_lp-1:0]  rs1_o,
    input  logic [lanes_p-1:0]          lane_done_i,
    input  logic [lanes_p-1:0]          lane_v_i,
    input  logic [lanes_p*vdw_p-1:0]    lane_r_data_i,
    output logic                        resp_v_o,
    input  logic                        resp_ready_i,
    output logic [vlen_p*vdw_p-1:0]     resp_data_o
);

    localparam int unsigned beats_lp      = vlen_p / lanes_p;
    localparam int unsigned beat_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam logic [op_width_p-1:0] read_op_lp = op_width_p'(4'b1000);
    localparam logic [beat_width_lp-1:0] beat_max_lp = beat_width_lp'(beats_lp - 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

    state_e                      state_q, state_d;
    logic [lanes_p-1:0]          sticky_q, sticky_d;
    logic [beat_width_lp-1:0]    beat_q, beat_d;
    logic [vlen_p*vdw_p-1:0]     resp_data_q, resp_data_d;
    logic [op_width_p-1:0]       op_q;
    logic [v_addr_width_lp-1:0]  rd_q, rs0_q, rs1_q;
    logic [vdw_p-1:0]            scalar_q, w_data_q;
    logic                        accept;

    // Lanes stream in lockstep, so lane 0's valid qualifies the whole beat.
    logic unused_lane_v;
    assign unused_lane_v = ^lane_v_i;

    assign accept = (state_q == StIdle) && instr_v_i;

    always_comb begin
        state_d       = state_q;
        sticky_d      = sticky_q;
        beat_d        = beat_q;
        resp_data_d   = resp_data_q;
        instr_ready_o = 1'b0;
        start_o       = 1'b0;
        resp_v_o      = 1'b0;
        unique case (state_q)
            StIdle: begin
                instr_ready_o = 1'b1;
                if (instr_v_i) begin
                    sticky_d    = '0;
                    beat_d      = '0;
                    resp_data_d = '0;
                    state_d     = StStart;
                end
            end
            StStart: begin
                start_o = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                sticky_d = sticky_q | lane_done_i;
                if (&sticky_d) begin
                    state_d = StResp;
                end
                if ((op_q == read_op_lp) && lane_v_i[0]) begin
                    for (int l = 0; l < int'(lanes_p); l++) begin
                        resp_data_d[(int'(beat_q) * int'(lanes_p) + l) * int'(vdw_p) +: vdw_p] =
                            lane_r_data_i[l * int'(vdw_p) +: vdw_p];
                    end
                    if (beat_q != beat_max_lp) begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StResp: begin
                resp_v_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= StIdle;
            sticky_q    <= '0;
            beat_q      <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            sticky_q    <= sticky_d;
            beat_q      <= beat_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Holding registers load only on accept so lane-side signals stay frozen while lanes work.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            op_q     <= '0;
            rd_q     <= '0;
            rs0_q    <= '0;
            rs1_q    <= '0;
            scalar_q <= '0;
            w_data_q <= '0;
        end else if (accept) begin
            op_q     <= instr_op_i;
            rd_q     <= instr_rd_i;
            rs0_q    <= instr_rs0_i;
            rs1_q    <= instr_rs1_i;
            scalar_q <= instr_scalar_i;
            w_data_q <= instr_w_data_i;
        end
    end

    assign op_o        = op_q;
    assign rd_o        = rd_q;
    assign rs0_o       = rs0_q;
    assign rs1_o       = rs1_q;
    assign scalar_o    = scalar_q;
    assign w_data_o    = w_data_q;
    assign resp_data_o = resp_data_q;

endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Scoreboard bench for vector_issue_ctrl: a transaction-level model predicts handshakes,
// start/response timing and read vectors; a lane model answers start pulses.
module tb_vector_issue_ctrl;

    localparam int LANES = 4;
    localparam int VLEN  = 8;
    localparam int VDW   = 32;
    localparam int V     = VLEN / LANES;
    localparam int VW    = VLEN * VDW;
    localparam logic [3:0] READ = 4'b1000;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            instr_v;
    logic            instr_ready;
    logic [3:0]      instr_op;
    logic [4:0]      instr_rd, instr_rs0, instr_rs1;
    logic [31:0]     instr_scalar, instr_w_data;
    logic [3:0]      op;
    logic            start;
    logic [31:0]     scalar, w_data;
    logic [4:0]      rd, rs0, rs1;
    logic [3:0]      lane_done, lane_v;
    logic [LANES*VDW-1:0] lane_r_data;
    logic            resp_v, resp_ready;
    logic [VW-1:0]   resp_data;

    vector_issue_ctrl dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .instr_v_i      (instr_v),
        .instr_ready_o  (instr_ready),
        .instr_op_i     (instr_op),
        .instr_rd_i     (instr_rd),
        .instr_rs0_i    (instr_rs0),
        .instr_rs1_i    (instr_rs1),
        .instr_scalar_i (instr_scalar),
        .instr_w_data_i (instr_w_data),
        .op_o           (op),
        .start_o        (start),
        .scalar_o       (scalar),
        .w_data_o       (w_data),
        .rd_o           (rd),
        .rs0_o          (rs0),
        .rs1_o          (rs1),
        .lane_done_i    (lane_done),
        .lane_v_i       (lane_v),
        .lane_r_data_i  (lane_r_data),
        .resp_v_o       (resp_v),
        .resp_ready_i   (resp_ready),
        .resp_data_o    (resp_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state (updated on rising edges from stimulus only).
    int  mcyc = 0;
    bit  busy = 1'b0;
    int  start_at = -10, rise_at = 1 << 30, acc_at = 0, acc_cnt = 0, rst_at = -10;
    logic [3:0]  h_op = '0;
    logic [4:0]  h_rd = '0, h_rs0 = '0, h_rs1 = '0;
    logic [31:0] h_sc = '0, h_wd = '0;
    logic [VW-1:0] exp_q[$];

    // Per-instruction lane behaviour chosen by stimulus, copied by the model on accept.
    logic [31:0] s_base;
    int          s_dly[LANES];
    logic [3:0]  cur_op = '0;
    logic [31:0] cur_base = '0;
    int          cur_dly[LANES];
    int          cur_dbase = 0, cur_maxd = 0;
    int          rdy_mode = 0;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, mcyc, act, exp);
        end
    endtask

    // Transaction-level reference model.
    initial forever begin
        logic [VW-1:0] vec;
        @(posedge clk);
        mcyc++;
        if (!reset_n) begin
            busy = 1'b0;
            exp_q.delete();
            start_at = -10;
            rise_at  = 1 << 30;
            rst_at   = mcyc;
            {h_op, h_rd, h_rs0, h_rs1, h_sc, h_wd} = '0;
        end else if (busy) begin
            if (mcyc - 1 >= rise_at && resp_ready) busy = 1'b0;
        end else if (instr_v) begin
            busy = 1'b1;
            acc_cnt++;
            acc_at   = mcyc;
            start_at = mcyc;
            {h_op, h_rd, h_rs0, h_rs1, h_sc, h_wd} =
                {instr_op, instr_rd, instr_rs0, instr_rs1, instr_scalar, instr_w_data};
            cur_op   = instr_op;
            cur_base = s_base;
            cur_maxd = 0;
            for (int l = 0; l < LANES; l++) begin
                cur_dly[l] = s_dly[l];
                if (s_dly[l] > cur_maxd) cur_maxd = s_dly[l];
            end
            cur_dbase = 2 + V + ((instr_op == READ) ? 0 : 2);
            rise_at   = mcyc + cur_dbase + cur_maxd;
            vec = '0;
            if (instr_op == READ)
                for (int e = 0; e < VLEN; e++) vec[e*VDW +: VDW] = s_base + 32'(e);
            exp_q.push_back(vec);
        end
    end

    // Lane array model: loops V cycles after start, then reports done (with per-lane delay).
    initial forever begin
        int lt;
        @(negedge clk);
        lane_v = '0;
        lane_done = '0;
        lane_r_data = '0;
        if (!reset_n) begin
            lt = 0;
        end else if (start) begin
            lt = 1;
        end else if (lt > 0) begin
            lt++;
            if (lt > cur_dbase + cur_maxd) begin
                lt = 0;
            end else begin
                if (cur_op == READ && lt >= 2 && lt <= 1 + V) begin
                    lane_v = '1;
                    for (int l = 0; l < LANES; l++)
                        lane_r_data[l*VDW +: VDW] = cur_base + 32'(l + LANES * (lt - 2));
                end
                for (int l = 0; l < LANES; l++) lane_done[l] = (lt == cur_dbase + cur_dly[l]);
            end
        end else if ($urandom_range(3) == 0) begin
            // Stray activity while no instruction is in flight.
            lane_done   = 4'($urandom);
            lane_v      = 4'($urandom);
            lane_r_data = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Response consumer.
    initial forever begin
        @(negedge clk);
        case (rdy_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = 1'($urandom_range(1));
            default: resp_ready = (mcyc >= rise_at + 3);
        endcase
    end

    // Monitor / scoreboard checker.
    initial forever begin
        @(negedge clk);
        #1;
        chk("instr_ready", VW'(instr_ready), VW'(!busy));
        chk("start", VW'(start), VW'(busy && mcyc == start_at));
        chk("resp_v", VW'(resp_v), VW'(busy && mcyc >= rise_at));
        chk("lane_side", VW'({op, rd, rs0, rs1, scalar, w_data}),
            VW'({h_op, h_rd, h_rs0, h_rs1, h_sc, h_wd}));
        if (mcyc == rst_at) chk("reset_data", resp_data, '0);
        if (resp_v) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", VW'(resp_v), '0);
            end else begin
                chk("resp_data", resp_data, exp_q[0]);
                if (resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [4:0] d, input logic [4:0] a,
                         input logic [4:0] b, input logic [31:0] base,
                         input int d0, input int d1, input int d2, input int d3);
        int prev;
        instr_op = o;
        instr_rd = d;
        instr_rs0 = a;
        instr_rs1 = b;
        instr_scalar = $urandom;
        instr_w_data = $urandom;
        s_base = base;
        s_dly[0] = d0;
        s_dly[1] = d1;
        s_dly[2] = d2;
        s_dly[3] = d3;
        instr_v = 1'b1;
        prev = acc_cnt;
        for (int i = 0; i < 300 && acc_cnt == prev; i++) @(negedge clk);
        if (acc_cnt == prev) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept want accept");
        end
    endtask

    task automatic wait_idle();
        instr_v = 1'b0;
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy want idle");
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        instr_v = 1'b1;
        {instr_op, instr_rd, instr_rs0, instr_rs1} = {READ, 5'd1, 5'd2, 5'd3};
        instr_scalar = 32'hdead_beef;
        instr_w_data = 32'hcafe_f00d;
        s_base = '0;
        for (int l = 0; l < LANES; l++) s_dly[l] = 0;
        repeat (2) @(negedge clk);
        instr_v = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        issue(READ, 5'd1, 5'd2, 5'd3, 32'h100, 0, 0, 0, 0);
        wait_idle();
        issue(4'b0000, 5'd5, 5'd3, 5'd4, 32'h0, 0, 0, 0, 0);
        wait_idle();

        rdy_mode = 2;
        issue(READ, 5'd7, 5'd8, 5'd9, 32'h200, 0, 0, 0, 0);
        issue(4'b0011, 5'd10, 5'd11, 5'd12, 32'h0, 0, 0, 0, 0);
        wait_idle();
        rdy_mode = 0;

        issue(4'b0010, 5'd6, 5'd1, 5'd2, 32'h0, 0, 0, 3, 0);
        wait_idle();
        issue(READ, 5'd3, 5'd4, 5'd5, 32'h500, 0, 1, 3, 0);
        wait_idle();

        issue(READ, 5'd2, 5'd2, 5'd2, 32'h300, 0, 0, 0, 0);
        instr_v = 1'b0;
        while (mcyc < acc_at + 2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(READ, 5'd4, 5'd5, 5'd6, 32'h400, 0, 0, 0, 0);
        wait_idle();

        rdy_mode = 1;
        for (int n = 0; n < 40; n++) begin
            logic [3:0] o;
            o = ($urandom_range(1) == 1) ? READ : 4'($urandom_range(15));
            issue(o, 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
                  $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3));
            if ($urandom_range(1) == 1) begin
                instr_v = 1'b0;
                repeat ($urandom_range(4)) @(negedge clk);
            end
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_issue_ctrl.md
# vector_issue_ctrl

Issue controller for the vector lane array. It accepts one vector instruction at a time over a valid/ready handshake and broadcasts the op, operands and a single-cycle start to all `lanes_p` lanes. It holds those lane-side signals stable until every lane has reported done, and assembles read-out elements streamed by the lanes into a full vector. It then returns a completion response over a second valid/ready handshake. It sits between the instruction front end and the lane/regfile array.

## Interface
- `lanes_p`, default 4: number of lanes driven; lane ids 0..lanes_p-1.
- `vlen_p`, default 8: elements per vector; must be a multiple of `lanes_p`.
- `vdw_p`, default 32: bits per element.
- `els_p`, default 32: vector registers; `v_addr_width_lp` = safe clog2(els_p).
- `op_width_p`, default 4: opcode width; 4'b1000 is READ, other codes are ALU/write ops.
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, synchronous, active-low.
- `instr_v_i` in 1: instruction valid.
- `instr_ready_o` out 1: controller can accept an instruction.
- `instr_op_i` in op_width_p: opcode.
- `instr_rd_i`, `instr_rs0_i`, `instr_rs1_i` in v_addr_width_lp: destination and source vector register numbers.
- `instr_scalar_i` in vdw_p: scalar operand.
- `instr_w_data_i` in vdw_p: external write/fill data.
- `op_o` out op_width_p: op broadcast to lanes.
- `start_o` out 1: start pulse to lanes.
- `scalar_o`, `w_data_o` out vdw_p: broadcast operands.
- `rd_o`, `rs0_o`, `rs1_o` out v_addr_width_lp: regfile bank selects.
- `lane_done_i` in lanes_p: per-lane done pulses.
- `lane_v_i` in lanes_p: per-lane read-data valid.
- `lane_r_data_i` in lanes_p*vdw_p: per-lane read data; lane l occupies bits [l*vdw_p +: vdw_p].
- `resp_v_o` out 1: response valid.
- `resp_ready_i` in 1: response consumer ready.
- `resp_data_o` out vlen_p*vdw_p: read vector; element e occupies bits [e*vdw_p +: vdw_p].

## Operation
- **States:** IDLE, START, WAIT, RESP.
- **IDLE:** `instr_ready_o`=1. On `instr_v_i`=1, latch op/rd/rs0/rs1/scalar/w_data into holding registers, clear the done-sticky vector and the beat counter, clear `resp_data_o`, and go to START.
- **START:** `start_o`=1 for exactly one cycle, then go to WAIT.
- **WAIT:**
  - Each cycle, OR `lane_done_i` into the sticky vector.
  - When (sticky | lane_done_i) is all ones, go to RESP.
- **RESP:** `resp_v_o`=1. When `resp_ready_i`=1, go to IDLE.
- **Lane-side outputs:** `op_o`, `scalar_o`, `w_data_o`, `rd_o`, `rs0_o`, `rs1_o` come from the holding registers. They are stable from the START cycle until the cycle after RESP completes. Lanes use the live op to generate done, so these outputs must never change while a lane is busy.
- **Read capture (READ op only, in WAIT):**
  - In each cycle with `lane_v_i[0]`=1, write `lane_r_data_i` lane l into element l + lanes_p*beat, then increment beat.
  - beat is clog2(vlen_p/lanes_p) wide and saturates at vlen_p/lanes_p-1.
- **Non-READ ops:** `resp_data_o` stays all-zero.
- **Boundary conditions:**
  - `lane_done_i` and `lane_v_i` are ignored outside WAIT.
  - `instr_v_i` is ignored while not in IDLE.
  - `resp_data_o` is held stable while `resp_v_o`=1.
  - Lanes finishing on different cycles are handled by the sticky vector; a lane's done is never lost.
  - Any reset cycle, including mid-WAIT or mid-RESP, forces IDLE and the reset values. The lanes' active-high reset is driven from the same source by integration.

## Timing
- **Reset values:**
  - `instr_ready_o`=1 (IDLE).
  - `start_o`, `resp_v_o` = 0.
  - `resp_data_o`, `op_o`, `scalar_o`, `w_data_o`, `rd_o`, `rs0_o`, `rs1_o` = 0.
- **Handshakes:**
  - Accept when `instr_v_i`&`instr_ready_o` at a rising edge (cycle 0). `start_o` is high in cycle 1.
  - Response transfers when `resp_v_o`&`resp_ready_i`. `instr_ready_o` is high the following cycle.
- **Lane timing, with V = vlen_p/lanes_p:**
  - Lanes loop in cycles 2..1+V and report done in cycle 2+V for READ, or 4+V for other ops (two pipeline stages).
  - `resp_v_o` rises in cycle 3+V for READ, or 5+V otherwise.
  - With defaults (V=2): cycle 5 for READ, cycle 7 otherwise.
- **Throughput:** back-to-back instructions have a minimum issue interval of resp latency + 1 cycle. No overlap.

## Test plan
- **Reset:** hold `reset_n_i`=0 two cycles with `instr_v_i`=1 → `instr_ready_o`=1, `start_o`=0, `resp_v_o`=0, all data outputs 0; no accept during reset.
- **READ:** lane model regfile element e = 32'h100+e, op 4'b1000, `resp_ready_i`=1 → `start_o` in cycle 1 only, `resp_v_o` in cycle 5, `resp_data_o` element e = 32'h100+e for e=0..7.
- **ADD:** op 4'b0000, rs0=3, rs1=4, rd=5 → `op_o`/`rs0_o`/`rs1_o`/`rd_o` constant cycles 1-7, `resp_v_o` in cycle 7, `resp_data_o`=0.
- **Backpressure:** `resp_ready_i`=0 for 3 cycles after `resp_v_o` rises, second `instr_v_i` asserted throughout → response and data held stable, `instr_ready_o`=0; second instruction accepted the cycle after the response transfers.
- **Staggered done:** lane 2 done delayed 3 cycles versus lanes 0,1,3 → `resp_v_o` rises exactly one cycle after lane 2's done; an extra stray done in IDLE causes no state change.
- **Reset mid-WAIT:** `reset_n_i`=0 in cycle 3 of READ → IDLE next cycle, `resp_v_o` never asserted; a fresh READ then completes normally with correct data.
